// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default payload width for the pipeline skid register
package pipe_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: load-enable payload register with synchronous active-low reset
module pipe_data_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q;
  always_ff @(posedge clk)
    if (!reset) data_q <= '0;
    else if (en_i) data_q <= d_i;
  assign q_o = data_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer with registered ready, full throughput and synchronous flush
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);
  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire, main_ld, skid_ld;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;
  assign main_d   = state_q == ST_FULL ? skid_q : in_data;
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        state_d = in_fire ? ST_BUSY : ST_EMPTY;
        main_ld = in_fire;
      end
      ST_BUSY: begin
        state_d = (in_fire & ~out_fire) ? ST_FULL : (~in_fire & out_fire) ? ST_EMPTY : ST_BUSY;
        main_ld = in_fire & out_fire;
        skid_ld = in_fire & ~out_fire;
      end
      ST_FULL: begin
        state_d = out_fire ? ST_BUSY : ST_FULL;
        main_ld = out_fire;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end
  assign in_ready_d = state_d != ST_FULL;
  always_ff @(posedge clk)
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );
  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en_i  (skid_ld),
    .d_i   (in_data),
    .q_o   (skid_q)
  );
  assign in_ready  = in_ready_q;
  assign out_valid = state_q != ST_EMPTY;
  assign out_data  = main_q;
  assign occupancy = state_q == ST_FULL ? CNT_W'(2) : state_q == ST_BUSY ? CNT_W'(1) : '0;
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Stall-aware pipeline register: the receiving end of a stage boundary. The plain capture register takes data every cycle; this block adds a valid/ready handshake toward both the producing and the consuming stage.
- Two-entry skid buffer (main + skid). It gives full throughput and a registered in_ready, so no combinational ready path crosses the stage.
- Sits between RISC-V pipeline stages (e.g. IF->ID, ID->EX). flush supports branch/exception squash.

Parameters:
- WIDTH, 8, payload width in bits
- CNT_W, 2, width of occupancy output (fixed at 2; values 0..2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clk)
- flush  input  1  squash all held entries; synchronous, priority over handshakes
- in_valid  input  1  upstream payload valid
- in_ready  output  1  registered; block can accept a payload this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  registered; out_data holds a valid payload
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  registered payload (main entry)
- occupancy  output  CNT_W  number of held entries, 0..2

Behaviour:
- Transfer rules: in-fire = in_valid & in_ready; out-fire = out_valid & out_ready. Both are evaluated on the rising clk.
- States, encoded in a 2-bit state register:
  - EMPTY (occ 0)
  - BUSY (occ 1, main valid)
  - FULL (occ 2, main + skid valid)
- Outputs:
  - out_valid = (state != EMPTY)
  - out_data = main_q
  - occupancy = 0 / 1 / 2 by state
- in_ready is a flop; next value = (next_state != FULL).
- Reset (reset==0 at an edge):
  - state <= EMPTY, main_q <= 0, skid_q <= 0, in_ready <= 0.
  - in_ready rises on the first edge with reset==1. Inputs are ignored while reset==0.
- Transitions, when not flushing:
  - EMPTY + in-fire -> main_q <= in_data, go to BUSY. Latency from in-fire to out_valid is 1 cycle.
  - BUSY, in-fire & out-fire -> main_q <= in_data, stay in BUSY (full throughput).
  - BUSY, in-fire only -> skid_q <= in_data, go to FULL. in_ready drops next cycle.
  - BUSY, out-fire only -> go to EMPTY.
  - FULL (in_ready=0), out-fire -> main_q <= skid_q, go to BUSY. in_ready rises next cycle.
  - Otherwise hold. While out_valid=1 and out_ready=0, out_data must not change.
- flush==1 (and reset==1):
  - next_state = EMPTY, in_ready <= 1.
  - Any same-cycle in-fire is discarded; any same-cycle out-fire completes downstream but its entry is not re-presented.
  - main_q/skid_q keep their values (don't-care while EMPTY).
- Reset has priority over flush. Reset asserted mid-stream drops all entries with no partial output.
- Ordering: payloads leave in strict arrival order. None is duplicated or dropped, except by flush or reset.
- Zero-bubble: with in_valid=out_ready=1 continuously, one payload per cycle after 1-cycle fill latency.
- Illegal state encoding (3) recovers to EMPTY on the next edge.

Decomposition:
- Shared package pipe_pkg:
  - state localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2
  - default WIDTH
- Optional sub-module pipe_data_reg: WIDTH-bit load-enable register with sync active-low reset. Instantiated twice, for main and skid.
- Next-state/ready logic stays in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1, in_data=8'hAA. Required: out_valid=0, in_ready=0, occupancy=0. One cycle after reset=1: in_ready=1, nothing captured.
- Streaming: out_ready=1, send 8'h01..8'h10 back-to-back. Required: out_data 8'h01..8'h10 in order, one per cycle, first at in-fire+1, in_ready never drops.
- Backpressure: out_ready=0, send 8'h11 and 8'h22. Required:
  - occupancy goes 1 then 2; in_ready=0 the cycle after 8'h22 is accepted; out_data stays 8'h11.
  - With out_ready=1, outputs 8'h11 then 8'h22; in_ready=1 after 8'h11 leaves.
- Simultaneous in/out in BUSY: main=8'h33, present 8'h44 with out_ready=1. Required: 8'h33 consumed, next cycle out_data=8'h44, occupancy stays 1.
- Flush: in FULL (8'h55, 8'h66), assert flush=1 with in_valid=1, in_data=8'h77 for one cycle. Required next cycle: out_valid=0, occupancy=0, in_ready=1. 8'h77 never appears at out_data.
- Reset mid-operation: in FULL, pulse reset=0 for one cycle. Required: EMPTY, in_ready=0 for that cycle, then 1. No stale data emitted afterwards.
